// File: rtl/led_ctrl_pkg.sv
// Shared types and default sizing for the LED scroll sequencer.
// SCROLL_PERIOD_DEF exists only when LED_AUTO_SCROLL_EN is defined.
package led_ctrl_pkg;

    localparam int DIGIT_W             = 4;
    localparam int MSG_LEN_DEF         = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
`ifdef LED_AUTO_SCROLL_EN
    localparam int SCROLL_PERIOD_DEF   = 50_000_000;
`endif

    typedef enum logic [1:0] {
        EMPTY,
        SHOW,
        ADVANCE,
        REFRESH
    } state_t;

endpackage

// File: rtl/led_scroll_ctrl_button_debouncer.sv
// Two-flop synchroniser, stable-level filter and one-cycle press pulse on an
// accepted 0->1 transition of the raw push-button.
module button_debouncer
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any return to the old level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], button};
            press  <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                press   <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_scroll_ctrl.sv
// Nibble message buffer with a wrapping 4-digit window for the LED driver.
// Define LED_AUTO_SCROLL_EN to add a periodic auto-advance every SCROLL_PERIOD cycles.
module led_scroll_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int MSG_LEN         = MSG_LEN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef LED_AUTO_SCROLL_EN
    ,
    parameter int SCROLL_PERIOD   = SCROLL_PERIOD_DEF
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       button,
    input  logic                       wr_valid,
    input  logic [DIGIT_W-1:0]         wr_data,
    output logic                       wr_ready,
    input  logic                       wr_clear,
    output logic [$clog2(MSG_LEN):0]   msg_len,
    output logic [DIGIT_W-1:0]         digit3,
    output logic [DIGIT_W-1:0]         digit2,
    output logic [DIGIT_W-1:0]         digit1,
    output logic [DIGIT_W-1:0]         digit0,
    output logic                       disp_update
);

    localparam int PTR_W = $clog2(MSG_LEN);
    localparam int LEN_W = PTR_W + 1;

    logic [DIGIT_W-1:0]            mem [MSG_LEN];
    logic [LEN_W-1:0]              len_q;
    logic [PTR_W-1:0]              ptr_q;
    logic [LEN_W-1:0]              ptr_inc;
    state_t                        state_q, state_d;
    logic                          press, adv_req, wr_fire;
    logic [3:0][DIGIT_W-1:0]       win, digits_q;
    logic                          disp_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .press  (press)
    );

`ifdef LED_AUTO_SCROLL_EN
    localparam int TICK_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCROLL_PERIOD - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt_q <= '0;
        else if (press || wr_clear || tick_cnt_q == TICK_LAST)
            tick_cnt_q <= '0;
        else
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
    end

    // Short messages fit on the display, so they never auto-scroll.
    assign tick    = (tick_cnt_q == TICK_LAST) && (len_q > LEN_W'(4));
    assign adv_req = press | tick;
`else
    assign adv_req = press;
`endif

    assign wr_ready = (len_q != LEN_W'(MSG_LEN)) && !wr_clear;
    assign wr_fire  = wr_valid && wr_ready;
    assign ptr_inc  = {1'b0, ptr_q} + LEN_W'(1);

    // NOTE: the message store has no reset; msg_len alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[len_q[PTR_W-1:0]] <= wr_data;
    end

    // Clear wins; an advance wraps against the length held before a same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
            ptr_q <= '0;
        end else if (wr_clear) begin
            len_q <= '0;
            ptr_q <= '0;
        end else begin
            if (wr_fire)
                len_q <= len_q + LEN_W'(1);
            if (state_q == ADVANCE && len_q != '0)
                ptr_q <= (ptr_inc == len_q) ? '0 : ptr_inc[PTR_W-1:0];
        end
    end

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [LEN_W-1:0] sum,
                                                   input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] r;
        r = sum;
        // ptr < len and offset <= 3, so three subtractions reach the true modulo.
        for (int i = 0; i < 3; i++)
            if (r >= len) r = r - len;
        return r[PTR_W-1:0];
    endfunction

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        win = '0;
        if (len_q != '0)
            for (int k = 0; k < 4; k++)
                win[3-k] = mem[wrap_idx({1'b0, ptr_q} + LEN_W'(k), len_q)];
    end

    always_comb begin
        state_d = state_q;
        if (wr_clear) begin
            state_d = REFRESH;
        end else begin
            case (state_q)
                EMPTY:   if (wr_fire) state_d = REFRESH;
                SHOW: begin
                    if (adv_req)      state_d = ADVANCE;
                    else if (wr_fire) state_d = REFRESH;
                end
                ADVANCE: state_d = adv_req ? ADVANCE : REFRESH;
                REFRESH: begin
                    if (adv_req && len_q != '0) state_d = ADVANCE;
                    else if (wr_fire)           state_d = REFRESH;
                    else if (len_q == '0)       state_d = EMPTY;
                    else                        state_d = SHOW;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            digits_q <= '0;
            disp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= 1'b0;
            if (state_q == REFRESH) begin
                digits_q <= win;
                disp_q   <= (win != digits_q);
            end
        end
    end

    assign msg_len     = len_q;
    assign digit3      = digits_q[3];
    assign digit2      = digits_q[2];
    assign digit1      = digits_q[1];
    assign digit0      = digits_q[0];
    assign disp_update = disp_q;

endmodule

// File: tb/tb_led_scroll_ctrl.sv
// Directed self-checking bench for led_scroll_ctrl; with LED_AUTO_SCROLL_EN a
// second instance with SCROLL_PERIOD=100 covers the auto-advance.
module tb_led_scroll_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_clear = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       wr_ready, disp_update;
    logic [4:0] msg_len;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [15:0] shown;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;

    always #5 clk = ~clk;

    led_scroll_ctrl #(.MSG_LEN(16), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .button(button), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_clear(wr_clear), .msg_len(msg_len), .digit3(digit3),
        .digit2(digit2), .digit1(digit1), .digit0(digit0), .disp_update(disp_update)
    );

    assign shown = {digit3, digit2, digit1, digit0};

    always @(negedge clk) if (disp_update === 1'b1) upd_cnt++;

`ifdef LED_AUTO_SCROLL_EN
    logic        a_wr_ready, a_disp_update;
    logic [4:0]  a_msg_len;
    logic [3:0]  a_d3, a_d2, a_d1, a_d0;
    logic [15:0] a_shown;

    led_scroll_ctrl #(.MSG_LEN(16), .DEBOUNCE_CYCLES(16), .SCROLL_PERIOD(100)) dut_auto (
        .clk(clk), .reset(reset), .button(button), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(a_wr_ready), .wr_clear(wr_clear), .msg_len(a_msg_len), .digit3(a_d3),
        .digit2(a_d2), .digit1(a_d1), .digit0(a_d0), .disp_update(a_disp_update)
    );

    assign a_shown = {a_d3, a_d2, a_d1, a_d0};
`endif

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Writes n nibbles back to back, first nibble taken from the most significant end.
    task automatic write_seq(input logic [63:0] nibs, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = nibs[4*(n-1-i) +: 4];
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        wr_clear = 1'b1;
        @(negedge clk);
        wr_clear = 1'b0;
    endtask

    task automatic hold_button(input int n);
        @(negedge clk);
        button = 1'b1;
        repeat (n) @(negedge clk);
        button = 1'b0;
        wait_cycles(30);
    endtask

    task automatic test_reset();
        #200;
        checks += 4;
        if (shown !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h expected 0000", shown); end
        if (disp_update !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b expected 0", disp_update); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        if (msg_len !== 5'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", msg_len); end
        @(negedge clk);
        reset = 1'b1;
        wait_cycles(3);
        checks += 3;
        if (shown !== 16'h0000) begin errors++; $display("FAIL post_reset_digits: got %h expected 0000", shown); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", wr_ready); end
        if (upd_cnt !== 0) begin errors++; $display("FAIL post_reset_upd: got %0d expected 0", upd_cnt); end
    endtask

    task automatic test_scroll();
        int u0;
        write_seq(64'h12345, 5);
        wait_cycles(3);
        checks += 2;
        if (shown !== 16'h1234) begin errors++; $display("FAIL write5_digits: got %h expected 1234", shown); end
        if (msg_len !== 5'd5) begin errors++; $display("FAIL write5_len: got %0d expected 5", msg_len); end

        u0 = upd_cnt;
        hold_button(20);
        checks += 2;
        if (shown !== 16'h2345) begin errors++; $display("FAIL press1_digits: got %h expected 2345", shown); end
        if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL press1_upd: got %0d expected 1", upd_cnt - u0); end

        u0 = upd_cnt;
        hold_button(20);
        checks += 2;
        if (shown !== 16'h3451) begin errors++; $display("FAIL press2_digits: got %h expected 3451", shown); end
        if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL press2_upd: got %0d expected 1", upd_cnt - u0); end

        u0 = upd_cnt;
        hold_button(1000);
        checks += 2;
        if (shown !== 16'h4512) begin errors++; $display("FAIL long_hold_digits: got %h expected 4512", shown); end
        if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL long_hold_upd: got %0d expected 1", upd_cnt - u0); end
    endtask

    task automatic test_glitch();
        int u0;
        u0 = upd_cnt;
        hold_button(5);
        checks += 2;
        if (shown !== 16'h4512) begin errors++; $display("FAIL glitch_digits: got %h expected 4512", shown); end
        if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL glitch_upd: got %0d expected 0", upd_cnt - u0); end
    endtask

    task automatic test_short_msg();
        pulse_clear();
        wait_cycles(2);
        checks += 2;
        if (shown !== 16'h0000) begin errors++; $display("FAIL clear_digits: got %h expected 0000", shown); end
        if (msg_len !== 5'd0) begin errors++; $display("FAIL clear_len: got %0d expected 0", msg_len); end
        write_seq(64'hAB, 2);
        wait_cycles(2);
        checks += 1;
        if (shown !== 16'hABAB) begin errors++; $display("FAIL len2_digits: got %h expected ABAB", shown); end
        hold_button(20);
        checks += 1;
        if (shown !== 16'hBABA) begin errors++; $display("FAIL len2_press1: got %h expected BABA", shown); end
        hold_button(20);
        checks += 1;
        if (shown !== 16'hABAB) begin errors++; $display("FAIL len2_press2: got %h expected ABAB", shown); end
    endtask

    task automatic test_full();
        pulse_clear();
        write_seq(64'h0123456789ABCDEF, 16);
        wait_cycles(2);
        checks += 3;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", wr_ready); end
        if (msg_len !== 5'd16) begin errors++; $display("FAIL full_len: got %0d expected 16", msg_len); end
        if (shown !== 16'h0123) begin errors++; $display("FAIL full_digits: got %h expected 0123", shown); end
        write_seq(64'h9, 1);
        wait_cycles(2);
        checks += 2;
        if (msg_len !== 5'd16) begin errors++; $display("FAIL overflow_len: got %0d expected 16", msg_len); end
        if (shown !== 16'h0123) begin errors++; $display("FAIL overflow_digits: got %h expected 0123", shown); end

        @(negedge clk);
        wr_clear = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 4'h7;
        #1;
        checks += 1;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b expected 0", wr_ready); end
        @(negedge clk);
        wr_clear = 1'b0;
        wr_valid = 1'b0;
        wait_cycles(2);
        checks += 2;
        if (msg_len !== 5'd0) begin errors++; $display("FAIL clear_write_len: got %0d expected 0", msg_len); end
        if (shown !== 16'h0000) begin errors++; $display("FAIL clear_write_digits: got %h expected 0000", shown); end
    endtask

    task automatic test_empty_advance();
        int u0;
        u0 = upd_cnt;
        hold_button(20);
        checks += 3;
        if (shown !== 16'h0000) begin errors++; $display("FAIL empty_adv_digits: got %h expected 0000", shown); end
        if (msg_len !== 5'd0) begin errors++; $display("FAIL empty_adv_len: got %0d expected 0", msg_len); end
        if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL empty_adv_upd: got %0d expected 0", upd_cnt - u0); end
    endtask

    task automatic test_reset_mid();
        write_seq(64'h789, 3);
        wait_cycles(2);
        checks += 1;
        if (shown !== 16'h7897) begin errors++; $display("FAIL len3_digits: got %h expected 7897", shown); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 4;
        if (shown !== 16'h0000) begin errors++; $display("FAIL midreset_digits: got %h expected 0000", shown); end
        if (msg_len !== 5'd0) begin errors++; $display("FAIL midreset_len: got %0d expected 0", msg_len); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", wr_ready); end
        if (disp_update !== 1'b0) begin errors++; $display("FAIL midreset_disp: got %b expected 0", disp_update); end
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(3);
        checks += 1;
        if (shown !== 16'h0000) begin errors++; $display("FAIL midreset_after: got %h expected 0000", shown); end
    endtask

`ifdef LED_AUTO_SCROLL_EN
    task automatic test_auto_scroll();
        pulse_clear();
        write_seq(64'h123456, 6);
        wait_cycles(143);
        checks += 1;
        if (a_shown !== 16'h2345) begin errors++; $display("FAIL auto_tick1: got %h expected 2345", a_shown); end
        wait_cycles(100);
        checks += 1;
        if (a_shown !== 16'h3456) begin errors++; $display("FAIL auto_tick2: got %h expected 3456", a_shown); end

        pulse_clear();
        write_seq(64'h123, 3);
        wait_cycles(250);
        checks += 1;
        if (a_shown !== 16'h1231) begin errors++; $display("FAIL auto_len3: got %h expected 1231", a_shown); end

        pulse_clear();
        write_seq(64'h123456, 6);
        wait_cycles(143);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks += 2;
        if (a_shown !== 16'h0000) begin errors++; $display("FAIL auto_reset_digits: got %h expected 0000", a_shown); end
        if (a_msg_len !== 5'd0) begin errors++; $display("FAIL auto_reset_len: got %0d expected 0", a_msg_len); end
        @(negedge clk);
        reset = 1'b1;
        write_seq(64'h123456, 6);
        wait_cycles(73);
        checks += 1;
        if (a_shown !== 16'h1234) begin errors++; $display("FAIL auto_restart_early: got %h expected 1234", a_shown); end
        wait_cycles(70);
        checks += 1;
        if (a_shown !== 16'h2345) begin errors++; $display("FAIL auto_restart_tick: got %h expected 2345", a_shown); end
    endtask
`endif

    initial begin
        test_reset();
        test_scroll();
        test_glitch();
        test_short_msg();
        test_full();
        test_empty_advance();
        test_reset_mid();
`ifdef LED_AUTO_SCROLL_EN
        test_auto_scroll();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
